// File: rtl/tf_phase_scheduler.sv
// Demand-actuated phase scheduler for the T-intersection: main road rests green,
// turn and side phases are served on latched demand, emergency returns traffic to main green.
module tf_phase_scheduler #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned T_MAIN_G = 30,
  parameter int unsigned T_TURN_G = 30,
  parameter int unsigned T_SIDE_G = 20,
  parameter int unsigned T_YEL    = 4,
  parameter int unsigned T_ALLRED = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_turn,
  input  logic       req_side,
  input  logic       emerg,
  output logic [2:0] led_M1,
  output logic [2:0] led_M2,
  output logic [2:0] led_MT,
  output logic [2:0] led_S,
  output logic [2:0] phase,
  output logic       turn_pend,
  output logic       side_pend
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] LAST_MAIN   = 8'(T_MAIN_G - 1);
  localparam logic [7:0] LAST_TURN   = 8'(T_TURN_G - 1);
  localparam logic [7:0] LAST_SIDE   = 8'(T_SIDE_G - 1);
  localparam logic [7:0] LAST_YEL    = 8'(T_YEL - 1);
  localparam logic [7:0] LAST_ALLRED = 8'(T_ALLRED - 1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    M2_Y   = 3'd1,
    TURN_G = 3'd2,
    TURN_Y = 3'd3,
    SIDE_G = 3'd4,
    SIDE_Y = 3'd5,
    MAIN_Y = 3'd6,
    ALL_R  = 3'd7
  } state_e;

  typedef enum logic {
    TGT_MAIN = 1'b0,
    TGT_SIDE = 1'b1
  } target_e;

  state_e        state_q, state_d;
  target_e       target_q, target_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic          turn_pend_q, turn_pend_d;
  logic          side_pend_q, side_pend_d;
  logic [11:0]   leds_q, leds_d;
  logic          tick;
  logic          changing;

  // Head encodings per state, packed as {M1, M2, MT, S}.
  function automatic logic [11:0] decode(input state_e s);
    case (s)
      MAIN_G:  decode = {GRN, GRN, RED, RED};
      M2_Y:    decode = {GRN, YEL, RED, RED};
      TURN_G:  decode = {GRN, RED, GRN, RED};
      TURN_Y:  decode = {YEL, RED, YEL, RED};
      SIDE_G:  decode = {RED, RED, RED, GRN};
      SIDE_Y:  decode = {RED, RED, RED, YEL};
      MAIN_Y:  decode = {YEL, YEL, RED, RED};
      default: decode = {RED, RED, RED, RED};
    endcase
  endfunction

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      MAIN_G: begin
        if (tick && (tcnt_q >= LAST_MAIN) && !emerg) begin
          if (turn_pend_q)      state_d = M2_Y;
          else if (side_pend_q) state_d = MAIN_Y;
        end
      end
      M2_Y:   if (tick && tcnt_q == LAST_YEL) state_d = TURN_G;
      TURN_G: if (emerg || (tick && tcnt_q == LAST_TURN)) state_d = TURN_Y;
      TURN_Y: begin
        if (tick && tcnt_q == LAST_YEL) begin
          state_d  = ALL_R;
          target_d = (side_pend_q && !emerg) ? TGT_SIDE : TGT_MAIN;
        end
      end
      SIDE_G: if (emerg || (tick && tcnt_q == LAST_SIDE)) state_d = SIDE_Y;
      SIDE_Y: begin
        if (tick && tcnt_q == LAST_YEL) begin
          state_d  = ALL_R;
          target_d = TGT_MAIN;
        end
      end
      MAIN_Y: begin
        if (tick && tcnt_q == LAST_YEL) begin
          state_d  = ALL_R;
          target_d = TGT_SIDE;
        end
      end
      ALL_R: begin
        if (tick && tcnt_q == LAST_ALLRED)
          state_d = (target_q == TGT_SIDE && !emerg) ? SIDE_G : MAIN_G;
      end
      default: state_d = ALL_R;
    endcase
  end

  // Timing restarts on every state change so each phase lasts a whole number of ticks.
  always_comb begin
    changing = (state_d != state_q);
    presc_d  = (changing || tick) ? '0 : presc_q + PW'(1);
    tcnt_d   = tcnt_q;
    if (changing)                    tcnt_d = '0;
    else if (tick && tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
  end

  // Entering a green clears its own demand, taking priority over a request in that cycle.
  always_comb begin
    turn_pend_d = turn_pend_q;
    side_pend_d = side_pend_q;
    if (state_d == TURN_G && state_q != TURN_G)  turn_pend_d = 1'b0;
    else if (req_turn && state_q != TURN_G)      turn_pend_d = 1'b1;
    if (state_d == SIDE_G && state_q != SIDE_G)  side_pend_d = 1'b0;
    else if (req_side && state_q != SIDE_G)      side_pend_d = 1'b1;
    leds_d = decode(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ALL_R;
      target_q    <= TGT_MAIN;
      presc_q     <= '0;
      tcnt_q      <= '0;
      turn_pend_q <= 1'b0;
      side_pend_q <= 1'b0;
      leds_q      <= {RED, RED, RED, RED};
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      presc_q     <= presc_d;
      tcnt_q      <= tcnt_d;
      turn_pend_q <= turn_pend_d;
      side_pend_q <= side_pend_d;
      leds_q      <= leds_d;
    end
  end

  assign led_M1    = leds_q[11:9];
  assign led_M2    = leds_q[8:6];
  assign led_MT    = leds_q[5:3];
  assign led_S     = leds_q[2:0];
  assign phase     = state_q;
  assign turn_pend = turn_pend_q;
  assign side_pend = side_pend_q;

endmodule
